// File: rtl/multi_bank_cmd_arbiter_pkg.sv
// Shared types and widths for the bank command arbiter.
package multi_bank_cmd_arbiter_pkg;

  localparam int ADDR_BITS      = 14;
  localparam int BA_BITS        = 3;
  localparam int CMD_BITS       = 3;
  localparam int ISU_FIFO_WIDTH = CMD_BITS + ADDR_BITS + BA_BITS;

  localparam int T_RRD_DEF = 4;
  localparam int T_FAW_DEF = 20;
  localparam int T_WTR_DEF = 6;

  typedef enum logic [CMD_BITS-1:0] {
    ATCMD_NOP       = 3'd0,
    ATCMD_ACTIVE    = 3'd1,
    ATCMD_READ      = 3'd2,
    ATCMD_WRITE     = 3'd3,
    ATCMD_RDA       = 3'd4,
    ATCMD_WRA       = 3'd5,
    ATCMD_PRECHARGE = 3'd6,
    ATCMD_REFRESH   = 3'd7
  } sch_cmd_t;

  typedef enum logic [1:0] {
    CLS_REF = 2'd0,
    CLS_PRE = 2'd1,
    CLS_ACT = 2'd2,
    CLS_RW  = 2'd3
  } arb_class_t;

  // One issue-FIFO word, command in the top bits.
  typedef struct packed {
    sch_cmd_t             cmd;
    logic [ADDR_BITS-1:0] addr;
    logic [BA_BITS-1:0]   bank;
  } isu_entry_t;

  function automatic arb_class_t cmd_class(sch_cmd_t c);
    case (c)
      ATCMD_REFRESH:   return CLS_REF;
      ATCMD_PRECHARGE: return CLS_PRE;
      ATCMD_ACTIVE:    return CLS_ACT;
      default:         return CLS_RW;
    endcase
  endfunction

  function automatic logic is_read(sch_cmd_t c);
    return (c == ATCMD_READ) || (c == ATCMD_RDA);
  endfunction

  function automatic logic is_write(sch_cmd_t c);
    return (c == ATCMD_WRITE) || (c == ATCMD_WRA);
  endfunction

endpackage

// File: rtl/multi_bank_cmd_arbiter_if.sv
// Bank-side request bus plus issue-FIFO write port of the arbiter.
interface multi_bank_cmd_arbiter_if
  import multi_bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = 8
) ();

  logic [NUM_BANKS-1:0]                ba_req;
  logic [NUM_BANKS-1:0][CMD_BITS-1:0]  ba_cmd;
  logic [NUM_BANKS-1:0][ADDR_BITS-1:0] ba_addr;
  logic                                isu_fifo_full;
  logic [NUM_BANKS-1:0]                ba_stall;
  logic [ISU_FIFO_WIDTH-1:0]           sch_out;
  logic                                sch_issue;

  // Banks and FIFO side.
  modport master (
    output ba_req, ba_cmd, ba_addr, isu_fifo_full,
    input  ba_stall, sch_out, sch_issue
  );

  // Arbiter side.
  modport slave (
    input  ba_req, ba_cmd, ba_addr, isu_fifo_full,
    output ba_stall, sch_out, sch_issue
  );

endinterface

// File: rtl/act_window_tracker.sv
// ACTIVE spacing: tRRD down-counter plus four tFAW slots.
module act_window_tracker #(
  parameter int T_RRD = 4,
  parameter int T_FAW = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic act_grant,
  output logic act_ok
);

  localparam int RW = (T_RRD > 1) ? $clog2(T_RRD) : 1;
  localparam int FW = (T_FAW > 1) ? $clog2(T_FAW) : 1;
  localparam int SLOTS = 4;

  logic [RW-1:0]            trrd_q;
  logic [SLOTS-1:0][FW-1:0] faw_q;
  logic [SLOTS-1:0]         slot_free;
  logic [SLOTS-1:0]         load_sel;

  // Pick the lowest free slot for the next ACT; none free means window full.
  always_comb begin
    load_sel = '0;
    for (int s = 0; s < SLOTS; s++) begin
      slot_free[s] = (faw_q[s] == '0);
      if (slot_free[s] && (load_sel == '0)) load_sel[s] = 1'b1;
    end
  end

  assign act_ok = (trrd_q == '0) && (|slot_free);

  // tRRD reload on every ACT grant, otherwise count down to ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               trrd_q <= '0;
    else if (act_grant)       trrd_q <= RW'(T_RRD - 1);
    else if (trrd_q != '0)    trrd_q <= trrd_q - 1'b1;
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_faw
    // Each slot holds one ACT for the rolling window, freeing itself at 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      faw_q[s] <= '0;
      else if (act_grant && load_sel[s]) faw_q[s] <= FW'(T_FAW - 1);
      else if (faw_q[s] != '0)         faw_q[s] <= faw_q[s] - 1'b1;
    end
  end

endmodule

// File: rtl/multi_bank_cmd_arbiter.sv
// Picks one bank command per cycle for the issue FIFO: class priority,
// starvation promotion, read/write burst grouping, age then round-robin.
module multi_bank_cmd_arbiter
  import multi_bank_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int T_RRD     = T_RRD_DEF,
  parameter int T_FAW     = T_FAW_DEF,
  parameter int T_WTR     = T_WTR_DEF,
  parameter int RW_BURST  = 4,
  parameter int STARVE_TH = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  multi_bank_cmd_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BW    = $clog2(RW_BURST + 1);
  localparam int WW    = (T_WTR > 1) ? $clog2(T_WTR) : 1;

  sch_cmd_t                  cmd_arr [NUM_BANKS];
  logic [NUM_BANKS-1:0][7:0] age_q;
  logic [NUM_BANKS-1:0]      elig, starved, is_rd, is_wr;
  logic [NUM_BANKS-1:0]      cls_ref, cls_pre, cls_act;
  logic [NUM_BANKS-1:0]      rd_set, wr_set, cur_set, opp_set, cand, gnt_vec;
  logic                      act_ok, act_grant, wtr_ok;
  logic                      found, gnt_valid, gnt_rd, gnt_wr;
  logic [IDX_W-1:0]          gnt_idx, rr_q, idx;
  logic [7:0]                best_age;
  logic [BW-1:0]             burst_q;
  logic                      dir_wr_q;
  logic [WW-1:0]             wtr_q;
  sch_cmd_t                  gnt_cmd;
  isu_entry_t                nxt_entry;

  assign wtr_ok = (wtr_q == '0);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
    arb_class_t cls;
    logic       ok;

    assign cmd_arr[i] = sch_cmd_t'(bus.ba_cmd[i]);
    assign cls        = cmd_class(cmd_arr[i]);
    assign is_rd[i]   = is_read(cmd_arr[i]);
    assign is_wr[i]   = is_write(cmd_arr[i]);
    assign ok         = bus.ba_req[i] && !bus.isu_fifo_full && (cmd_arr[i] != ATCMD_NOP);
    assign cls_ref[i] = (cls == CLS_REF);
    assign cls_pre[i] = (cls == CLS_PRE);
    assign cls_act[i] = (cls == CLS_ACT);
    // Timing masks apply before selection so a blocked bank never wins.
    assign elig[i]    = ok && (!cls_act[i] || act_ok) && (!is_rd[i] || wtr_ok);
    assign starved[i] = elig[i] && (int'(age_q[i]) >= STARVE_TH);

    // Age tracks how long the current request has waited; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          age_q[i] <= '0;
      else if (!bus.ba_req[i] || gnt_vec[i]) age_q[i] <= '0;
      else if (age_q[i] != 8'hFF)          age_q[i] <= age_q[i] + 8'd1;
    end
  end

  // Candidate set: starved first, then REF > PRE > ACT > read/write group.
  always_comb begin
    rd_set  = elig & is_rd;
    wr_set  = elig & is_wr;
    cur_set = dir_wr_q ? wr_set : rd_set;
    opp_set = dir_wr_q ? rd_set : wr_set;
    cand    = '0;
    if (|starved)                 cand = starved;
    else if (|(elig & cls_ref))   cand = elig & cls_ref;
    else if (|(elig & cls_pre))   cand = elig & cls_pre;
    else if (|(elig & cls_act))   cand = elig & cls_act;
    else if (int'(burst_q) < RW_BURST) cand = (|cur_set) ? cur_set : opp_set;
    else                          cand = (|opp_set) ? opp_set : cur_set;
  end

  // Oldest candidate wins; strict compare keeps the first one from rr_q on ties.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    best_age = '0;
    idx      = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx = IDX_W'((int'(rr_q) + k) % NUM_BANKS);
      if (cand[idx] && (!found || (age_q[idx] > best_age))) begin
        found    = 1'b1;
        gnt_idx  = idx;
        best_age = age_q[idx];
      end
    end
  end

  // Grant decode; reset forces every bank stalled.
  always_comb begin
    gnt_valid = found && rst_n;
    gnt_cmd   = cmd_arr[gnt_idx];
    gnt_rd    = gnt_valid && is_read(gnt_cmd);
    gnt_wr    = gnt_valid && is_write(gnt_cmd);
    act_grant = gnt_valid && (gnt_cmd == ATCMD_ACTIVE);
    for (int i = 0; i < NUM_BANKS; i++)
      gnt_vec[i] = gnt_valid && (gnt_idx == IDX_W'(i));
    nxt_entry = '{cmd: gnt_cmd, addr: bus.ba_addr[gnt_idx], bank: BA_BITS'(gnt_idx)};
  end

  assign bus.ba_stall = ~gnt_vec;

  act_window_tracker #(
    .T_RRD (T_RRD),
    .T_FAW (T_FAW)
  ) u_act_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_grant (act_grant),
    .act_ok    (act_ok)
  );

  // Registered FIFO write one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sch_issue <= 1'b0;
      bus.sch_out   <= '0;
    end else begin
      bus.sch_issue <= gnt_valid;
      if (gnt_valid) bus.sch_out <= nxt_entry;
    end
  end

  // Round-robin pointer moves past the last granted bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_q <= '0;
    else if (gnt_valid) rr_q <= IDX_W'((int'(gnt_idx) + 1) % NUM_BANKS);
  end

  // Burst grouping: direction flip restarts the count, same direction saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_wr_q <= 1'b1;
      burst_q  <= '0;
    end else if (gnt_rd || gnt_wr) begin
      if (gnt_wr != dir_wr_q) begin
        dir_wr_q <= gnt_wr;
        burst_q  <= BW'(1);
      end else if (int'(burst_q) < RW_BURST) begin
        burst_q  <= burst_q + 1'b1;
      end
    end
  end

  // Write-to-read turnaround counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            wtr_q <= '0;
    else if (gnt_wr)       wtr_q <= WW'(T_WTR - 1);
    else if (wtr_q != '0)  wtr_q <= wtr_q - 1'b1;
  end

endmodule

// File: tb/tb_multi_bank_cmd_arbiter.sv
// Directed bench for multi_bank_cmd_arbiter with an issue scoreboard.
module tb_multi_bank_cmd_arbiter;
  import multi_bank_cmd_arbiter_pkg::*;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_bank_cmd_arbiter_if #(.NUM_BANKS(NB)) bif ();

  multi_bank_cmd_arbiter #(.NUM_BANKS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NB-1:0]        req;
  sch_cmd_t             bcmd  [NB];
  logic [ADDR_BITS-1:0] baddr [NB];
  logic                 full;

  typedef struct {
    logic [ISU_FIFO_WIDTH-1:0] data;
    int                        cyc;
  } exp_t;
  exp_t sb [$];
  exp_t e;

  always_comb begin
    bif.ba_req        = req;
    bif.isu_fifo_full = full;
    for (int i = 0; i < NB; i++) begin
      bif.ba_cmd[i]  = bcmd[i];
      bif.ba_addr[i] = baddr[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Issue monitor: an entry pushed in an earlier cycle must appear now.
  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      assert (bif.sch_issue === 1'b0) else begin
        errors++; $error("FAIL issue_in_reset: got %b want 0", bif.sch_issue);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      assert (bif.sch_issue === 1'b1 && bif.sch_out === e.data) else begin
        errors++; $error("FAIL issue_data: got issue=%b out=%h want issue=1 out=%h",
                         bif.sch_issue, bif.sch_out, e.data);
      end
    end else begin
      checks++;
      assert (bif.sch_issue === 1'b0) else begin
        errors++; $error("FAIL issue_idle: got %b want 0", bif.sch_issue);
      end
    end
  end

  // One cycle: compare stalls, record expected issue, bank drops req on grant.
  task automatic chk(input int exp_idx, input string tag);
    logic [NB-1:0] want;
    @(negedge clk);
    want = '1;
    if (exp_idx >= 0) want[exp_idx] = 1'b0;
    checks++;
    assert (bif.ba_stall === want) else begin
      errors++; $error("FAIL %s: stall got %b want %b", tag, bif.ba_stall, want);
    end
    if (exp_idx >= 0)
      sb.push_back('{data: {bcmd[exp_idx], baddr[exp_idx], BA_BITS'(exp_idx)}, cyc: cyc});
    @(posedge clk); #1;
    if (exp_idx >= 0) req[exp_idx] = 1'b0;
  endtask

  task automatic do_reset();
    req  = '0;
    full = 1'b0;
    for (int i = 0; i < NB; i++) bcmd[i] = ATCMD_NOP;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int b, input sch_cmd_t c);
    bcmd[b] = c;
    req[b]  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) baddr[i] = ADDR_BITS'(14'h100 + i * 17);
    req  = '0;
    full = 1'b0;
    for (int i = 0; i < NB; i++) bcmd[i] = ATCMD_NOP;
    #2;
    do_reset();

    // Reset state: idle, nothing issued.
    chk(-1, "reset_idle");

    // REFRESH beats ACTIVE; ACT follows next cycle.
    do_reset();
    set_req(2, ATCMD_REFRESH);
    set_req(5, ATCMD_ACTIVE);
    chk(2, "ref_first");
    chk(5, "act_second");
    chk(-1, "t1_tail");

    // Class order REF > PRE > ACT > READ.
    do_reset();
    set_req(0, ATCMD_READ);
    set_req(1, ATCMD_ACTIVE);
    set_req(2, ATCMD_PRECHARGE);
    set_req(3, ATCMD_REFRESH);
    chk(3, "cls_ref");
    chk(2, "cls_pre");
    chk(1, "cls_act");
    chk(0, "cls_rd");
    chk(-1, "cls_tail");

    // tRRD = 4 and at most four ACTs in a 20-cycle window.
    do_reset();
    for (int b = 0; b < NB; b++) set_req(b, ATCMD_ACTIVE);
    for (int c = 0; c <= 20; c++) begin
      int x;
      x = (c % 4 == 0 && c <= 12) ? c / 4 : ((c == 20) ? 4 : -1);
      chk(x, "act_spacing");
    end
    chk(-1, "act_tail");

    // WRITE then READ: tWTR holds the read off for 6 cycles.
    do_reset();
    set_req(0, ATCMD_WRITE);
    set_req(1, ATCMD_READ);
    chk(0, "wtr_wr");
    repeat (5) chk(-1, "wtr_hold");
    chk(1, "wtr_rd");
    chk(-1, "wtr_tail");

    // Four writes grouped, then the read once tWTR expires.
    do_reset();
    for (int b = 0; b < 4; b++) set_req(b, ATCMD_WRITE);
    set_req(4, ATCMD_RDA);
    for (int b = 0; b < 4; b++) chk(b, "burst_wr");
    repeat (5) chk(-1, "burst_wtr");
    chk(4, "burst_rd");
    chk(-1, "burst_tail");

    // FIFO full: no grants, age keeps counting, grant right after release.
    do_reset();
    full = 1'b1;
    set_req(3, ATCMD_PRECHARGE);
    repeat (10) chk(-1, "full_hold");
    checks++;
    assert (dut.age_q[3] === 8'd10) else begin
      errors++; $error("FAIL full_age: got %0d want 10", dut.age_q[3]);
    end
    full = 1'b0;
    chk(3, "full_release");
    chk(-1, "full_tail");

    // Older request beats the round-robin favourite.
    do_reset();
    full = 1'b1;
    set_req(7, ATCMD_WRITE);
    repeat (3) chk(-1, "age_hold");
    set_req(0, ATCMD_WRITE);
    full = 1'b0;
    chk(7, "age_oldest");
    chk(0, "age_next");
    chk(-1, "age_tail");

    // Starved WRITE promoted above a fresh REFRESH.
    do_reset();
    full = 1'b1;
    set_req(0, ATCMD_WRITE);
    repeat (64) chk(-1, "starve_hold");
    set_req(1, ATCMD_REFRESH);
    full = 1'b0;
    chk(0, "starve_win");
    chk(1, "starve_ref");
    chk(-1, "starve_tail");

    // Reset the cycle after a grant drops the issue and timing state.
    do_reset();
    set_req(2, ATCMD_ACTIVE);
    set_req(5, ATCMD_ACTIVE);
    chk(2, "rst_grant");
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    assert (bif.sch_issue === 1'b0) else begin
      errors++; $error("FAIL rst_issue: got %b want 0", bif.sch_issue);
    end
    checks++;
    assert (bif.ba_stall === '1) else begin
      errors++; $error("FAIL rst_stall: got %b want all ones", bif.ba_stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk(5, "rst_fresh");
    chk(-1, "rst_tail");

    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL sb_drain: got %0d entries want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
